fetch_stage: RTL and testbench



---
 rtl/fetch_stage_pkg.sv | 18 +
 rtl/fetch_stage_pc_sel.sv | 46 ++++
 rtl/fetch_stage.sv | 182 ++++++++++++++++++
 tb/tb_fetch_stage.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/fetch_stage_pkg.sv
// fetch_stage_pkg: shared definitions for the instruction-fetch stage.
//   XLEN_DEFAULT  - default datapath/address width
//   NOP_INSTR     - canonical RISC-V NOP (addi x0, x0, 0) loaded on bubbles
//   PC_INC        - sequential PC step in bytes
//   fetch_state_e - fetch FSM state encoding
package fetch_stage_pkg;

  localparam int          XLEN_DEFAULT = 32;
  localparam logic [31:0] NOP_INSTR    = 32'h0000_0013;
  localparam int          PC_INC       = 4;

  typedef enum logic [1:0] {
    S_REQ  = 2'd0,  // request outstanding for fetch_pc
    S_HAVE = 2'd1,  // buffer holds the instruction for fetch_pc
    S_KILL = 2'd2   // stale request outstanding after a redirect
  } fetch_state_e;

endpackage

// File: rtl/fetch_stage_pc_sel.sv
// fetch_pc_sel: combinational next-PC selection for the fetch stage.
// Priority is int_trap > pc_src > advance > hold.
// Ports:
//   int_trap, trap_vector   - trap redirect and its target
//   pc_src, branch_target   - taken-branch redirect and its target
//   advance                 - sequential advance request
//   fetch_pc                - current fetch PC
//   next_pc                 - selected next PC
//   redirect                - a redirect (trap or branch) is selected
// Macro FETCH_MISALIGN_TRAP_EN: when undefined, redirect targets are forced
// to word alignment here; when defined, the raw target passes through so the
// top can flag it as misaligned.
module fetch_pc_sel
  import fetch_stage_pkg::*;
#(
  parameter int XLEN = XLEN_DEFAULT
) (
  input  logic            int_trap,
  input  logic            pc_src,
  input  logic            advance,
  input  logic [XLEN-1:0] trap_vector,
  input  logic [XLEN-1:0] branch_target,
  input  logic [XLEN-1:0] fetch_pc,
  output logic [XLEN-1:0] next_pc,
  output logic            redirect
);

  logic [XLEN-1:0] target;

  always_comb begin
    redirect = int_trap | pc_src;
    target   = int_trap ? trap_vector : branch_target;
`ifndef FETCH_MISALIGN_TRAP_EN
    target   = target & ~XLEN'(3);
`endif
    if (redirect) begin
      next_pc = target;
    end else if (advance) begin
      // Wraps modulo 2^XLEN by construction of the XLEN-wide add.
      next_pc = fetch_pc + XLEN'(PC_INC);
    end else begin
      next_pc = fetch_pc;
    end
  end

endmodule

// File: rtl/fetch_stage.sv
// fetch_stage: instruction-fetch stage of the 5-stage RISC-V pipeline.
// Owns the PC, issues single-outstanding requests to instruction memory,
// buffers the returned word and loads the IF/ID pipeline register.
// Ports:
//   clock, reset                  - clock (rising edge), async active-high reset
//   write_pc, write_ifid,
//   bubble_ifid, instr_en         - stall/bubble controls from the ID stage
//   pc_src, branch_target         - taken-branch redirect
//   int_trap, trap_vector         - trap redirect (higher priority)
//   imem_req, imem_addr           - memory request (held until imem_valid)
//   imem_valid, imem_rdata        - one-cycle memory response
//   fetch_ready                   - instruction available this cycle
//   ifid_pc, ifid_instr, ifid_valid - IF/ID pipeline register
//   fetch_misaligned              - only with FETCH_MISALIGN_TRAP_EN
// Macro FETCH_MISALIGN_TRAP_EN: enables misaligned-target detection; a
// misaligned redirect issues no request and the next advance loads
// {target, NOP, 1} with fetch_misaligned set.
module fetch_stage
  import fetch_stage_pkg::*;
#(
  parameter int              XLEN     = XLEN_DEFAULT,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            write_pc,
  input  logic            write_ifid,
  input  logic            bubble_ifid,
  input  logic            instr_en,
  input  logic            pc_src,
  input  logic [XLEN-1:0] branch_target,
  input  logic            int_trap,
  input  logic [XLEN-1:0] trap_vector,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_valid,
  input  logic [31:0]     imem_rdata,
  output logic            fetch_ready,
  output logic [XLEN-1:0] ifid_pc,
  output logic [31:0]     ifid_instr,
  output logic            ifid_valid
`ifdef FETCH_MISALIGN_TRAP_EN
  ,output logic           fetch_misaligned
`endif
);

  fetch_state_e    state_q, state_d;
  logic [XLEN-1:0] fetch_pc_q, kill_addr_q, kill_addr_d, ifid_pc_q, ifid_pc_d;
  logic [31:0]     buf_q, buf_d, ifid_instr_q, ifid_instr_d, payload;
  logic            ifid_valid_q, ifid_valid_d;
  logic            pend_mis_q, pend_mis_d;
  logic            advance, take_adv, redirect, mis_target;
  logic [XLEN-1:0] next_pc;
  fetch_state_e    fresh_state;

  assign fetch_ready = (state_q == S_HAVE) | ((state_q == S_REQ) & imem_valid);
  // A pending misaligned target has no fetched word; it presents a NOP.
  assign payload     = pend_mis_q ? NOP_INSTR :
                       (state_q == S_HAVE) ? buf_q : imem_rdata;
  assign advance     = fetch_ready & write_pc & write_ifid & instr_en & ~bubble_ifid;
  assign take_adv    = advance & ~redirect;

  fetch_pc_sel #(.XLEN(XLEN)) u_pc_sel (
    .int_trap      (int_trap),
    .pc_src        (pc_src),
    .advance       (advance),
    .trap_vector   (trap_vector),
    .branch_target (branch_target),
    .fetch_pc      (fetch_pc_q),
    .next_pc       (next_pc),
    .redirect      (redirect)
  );

`ifdef FETCH_MISALIGN_TRAP_EN
  assign mis_target = redirect & (next_pc[1:0] != 2'b00);
`else
  assign mis_target = 1'b0;
`endif

  // Where a new redirect target starts once the memory side is free:
  // a misaligned target skips the request and is immediately "available".
  assign fresh_state = mis_target ? S_HAVE : S_REQ;

  // The stale address stays on the bus while a killed request drains.
  assign imem_req   = (state_q != S_HAVE);
  assign imem_addr  = (state_q == S_KILL) ? kill_addr_q : fetch_pc_q;
  assign ifid_pc    = ifid_pc_q;
  assign ifid_instr = ifid_instr_q;
  assign ifid_valid = ifid_valid_q;

  always_comb begin
    state_d     = state_q;
    kill_addr_d = kill_addr_q;
    buf_d       = buf_q;
    pend_mis_d  = pend_mis_q;
    if (redirect) begin
      pend_mis_d = mis_target;
      case (state_q)
        S_REQ: begin
          if (imem_valid) begin
            state_d = fresh_state;
          end else begin
            state_d     = S_KILL;
            kill_addr_d = fetch_pc_q;
          end
        end
        S_HAVE:  state_d = fresh_state;
        // If the stale response lands in the same cycle as a further
        // redirect the bus is free, so waiting in S_KILL would hang.
        default: state_d = imem_valid ? fresh_state : S_KILL;
      endcase
    end else if (take_adv) begin
      state_d    = S_REQ;
      pend_mis_d = 1'b0;
    end else begin
      case (state_q)
        S_REQ: begin
          if (imem_valid) begin
            buf_d   = imem_rdata;
            state_d = S_HAVE;
          end
        end
        S_KILL: begin
          if (imem_valid) state_d = pend_mis_q ? S_HAVE : S_REQ;
        end
        default: ;
      endcase
    end

    ifid_pc_d    = ifid_pc_q;
    ifid_instr_d = ifid_instr_q;
    ifid_valid_d = ifid_valid_q;
    if (bubble_ifid) begin
      ifid_instr_d = NOP_INSTR;
      ifid_valid_d = 1'b0;
    end else if (take_adv) begin
      ifid_pc_d    = fetch_pc_q;
      ifid_instr_d = payload;
      ifid_valid_d = 1'b1;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q      <= S_REQ;
      fetch_pc_q   <= RESET_PC;
      kill_addr_q  <= RESET_PC;
      buf_q        <= NOP_INSTR;
      pend_mis_q   <= 1'b0;
      ifid_pc_q    <= '0;
      ifid_instr_q <= NOP_INSTR;
      ifid_valid_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      fetch_pc_q   <= next_pc;
      kill_addr_q  <= kill_addr_d;
      buf_q        <= buf_d;
      pend_mis_q   <= pend_mis_d;
      ifid_pc_q    <= ifid_pc_d;
      ifid_instr_q <= ifid_instr_d;
      ifid_valid_q <= ifid_valid_d;
    end
  end

`ifdef FETCH_MISALIGN_TRAP_EN
  logic mis_q, mis_d;

  always_comb begin
    mis_d = mis_q;
    if (bubble_ifid)   mis_d = 1'b0;
    else if (take_adv) mis_d = pend_mis_q;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) mis_q <= 1'b0;
    else       mis_q <= mis_d;
  end

  assign fetch_misaligned = mis_q;
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage: directed, table-driven bench for fetch_stage. The bench
// plays the instruction memory itself: each row states the memory response
// for that cycle together with the expected request and IF/ID contents.
module tb_fetch_stage;

  localparam logic [31:0] NOP   = 32'h0000_0013;
  localparam logic [4:0]  RUN   = 5'b11010;  // {write_pc, write_ifid, bubble_ifid, instr_en, pc_src}
  localparam logic [4:0]  STALL = 5'b00010;
  localparam logic [4:0]  BUB   = 5'b11110;
  localparam logic [4:0]  BR    = 5'b11011;
  localparam logic [4:0]  WP0   = 5'b01010;
  localparam logic [4:0]  NOEN  = 5'b11000;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        write_pc = 1'b1, write_ifid = 1'b1, bubble_ifid = 1'b0, instr_en = 1'b1;
  logic        pc_src = 1'b0, int_trap = 1'b0, imem_valid = 1'b0;
  logic [31:0] branch_target = '0, trap_vector = '0, imem_rdata = '0;
  logic        imem_req, fetch_ready, ifid_valid;
  logic [31:0] imem_addr, ifid_pc, ifid_instr;
`ifdef FETCH_MISALIGN_TRAP_EN
  logic        fetch_misaligned;
`endif

  int total = 0;
  int bad   = 0;

  fetch_stage dut (
    .clock         (clock),
    .reset         (reset),
    .write_pc      (write_pc),
    .write_ifid    (write_ifid),
    .bubble_ifid   (bubble_ifid),
    .instr_en      (instr_en),
    .pc_src        (pc_src),
    .branch_target (branch_target),
    .int_trap      (int_trap),
    .trap_vector   (trap_vector),
    .imem_req      (imem_req),
    .imem_addr     (imem_addr),
    .imem_valid    (imem_valid),
    .imem_rdata    (imem_rdata),
    .fetch_ready   (fetch_ready),
    .ifid_pc       (ifid_pc),
    .ifid_instr    (ifid_instr),
    .ifid_valid    (ifid_valid)
`ifdef FETCH_MISALIGN_TRAP_EN
    ,.fetch_misaligned (fetch_misaligned)
`endif
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [4:0]  ctl;
    logic [31:0] tgt;
    logic        vld;
    logic [31:0] rd;
    logic        ereq;
    logic [31:0] eaddr;
    logic        erdy;
    logic [31:0] epc;
    logic [31:0] einstr;
    logic        eval;
  } vec_t;

  vec_t tbl[$];

  // Distinct instruction word for each address.
  function automatic logic [31:0] iw(input logic [31:0] a);
    return 32'h0050_0000 ^ a;
  endfunction

  function automatic vec_t mk(input logic [4:0] ctl, input logic [31:0] tgt,
                              input logic vld, input logic [31:0] rd,
                              input logic ereq, input logic [31:0] eaddr, input logic erdy,
                              input logic [31:0] epc, input logic [31:0] einstr, input logic eval);
    vec_t v;
    v.ctl = ctl; v.tgt = tgt; v.vld = vld; v.rd = rd;
    v.ereq = ereq; v.eaddr = eaddr; v.erdy = erdy;
    v.epc = epc; v.einstr = einstr; v.eval = eval;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // One cycle: drive at negedge, check request side before the edge,
  // check IF/ID after the edge.
  task automatic step(input string nm, input logic [4:0] ctl, input logic it,
                      input logic [31:0] bt, input logic [31:0] tv,
                      input logic vld, input logic [31:0] rd,
                      input logic ereq, input logic [31:0] eaddr, input logic erdy,
                      input logic [31:0] epc, input logic [31:0] einstr, input logic eval);
    @(negedge clock);
    {write_pc, write_ifid, bubble_ifid, instr_en, pc_src} = ctl;
    int_trap = it; branch_target = bt; trap_vector = tv;
    imem_valid = vld; imem_rdata = rd;
    #1;
    chk({nm, ".req"},   32'(imem_req),    32'(ereq));
    chk({nm, ".addr"},  imem_addr,        eaddr);
    chk({nm, ".ready"}, 32'(fetch_ready), 32'(erdy));
    @(posedge clock);
    #1;
    chk({nm, ".ifid_pc"},    ifid_pc,         epc);
    chk({nm, ".ifid_instr"}, ifid_instr,      einstr);
    chk({nm, ".ifid_valid"}, 32'(ifid_valid), 32'(eval));
    $display("txn %-10s req=%b addr=%h rdy=%b ifid=%h/%h/%b",
             nm, ereq, imem_addr, erdy, ifid_pc, ifid_instr, ifid_valid);
  endtask

  initial begin
    // Sequential fetch with 1-cycle memory latency.
    tbl.push_back(mk(RUN,   0, 0, 0,            1, 32'h000, 0, 32'h000, NOP,          0));
    tbl.push_back(mk(RUN,   0, 1, iw(0),        1, 32'h000, 1, 32'h000, iw(0),        1));
    tbl.push_back(mk(RUN,   0, 0, 0,            1, 32'h004, 0, 32'h000, iw(0),        1));
    tbl.push_back(mk(RUN,   0, 1, iw(4),        1, 32'h004, 1, 32'h004, iw(4),        1));
    tbl.push_back(mk(RUN,   0, 0, 0,            1, 32'h008, 0, 32'h004, iw(4),        1));
    // Five-cycle stall while the word for PC 8 arrives, then release.
    tbl.push_back(mk(STALL, 0, 1, 32'h00A00093, 1, 32'h008, 1, 32'h004, iw(4),        1));
    for (int i = 0; i < 4; i++)
      tbl.push_back(mk(STALL, 0, 0, 0,          0, 32'h008, 1, 32'h004, iw(4),        1));
    tbl.push_back(mk(RUN,   0, 0, 0,            0, 32'h008, 1, 32'h008, 32'h00A00093, 1));
    // Bubble with fetch_ready: NOP/invalid into IF/ID, word kept in buffer.
    tbl.push_back(mk(BUB,   0, 1, iw(12),       1, 32'h00C, 1, 32'h008, NOP,          0));
    tbl.push_back(mk(RUN,   0, 0, 0,            0, 32'h00C, 1, 32'h00C, iw(12),       1));
    // Branch while the request is outstanding (latency 3): stale word discarded.
    tbl.push_back(mk(BR,    32'h100, 0, 0,      1, 32'h010, 0, 32'h00C, iw(12),       1));
    tbl.push_back(mk(RUN,   0, 0, 0,            1, 32'h010, 0, 32'h00C, iw(12),       1));
    tbl.push_back(mk(RUN,   0, 1, 32'hDEADBEEF, 1, 32'h010, 0, 32'h00C, iw(12),       1));
    tbl.push_back(mk(RUN,   0, 0, 0,            1, 32'h100, 0, 32'h00C, iw(12),       1));
    tbl.push_back(mk(RUN,   0, 1, iw(32'h100),  1, 32'h100, 1, 32'h100, iw(32'h100),  1));
    // Branch from S_HAVE drops the buffer; instr_en = 0 blocks the advance.
    tbl.push_back(mk(WP0,   0, 1, iw(32'h104),  1, 32'h104, 1, 32'h100, iw(32'h100),  1));
    tbl.push_back(mk(BR,    32'h200, 0, 0,      0, 32'h104, 1, 32'h100, iw(32'h100),  1));
    tbl.push_back(mk(NOEN,  0, 0, 0,            1, 32'h200, 0, 32'h100, iw(32'h100),  1));
    tbl.push_back(mk(NOEN,  0, 1, iw(32'h200),  1, 32'h200, 1, 32'h100, iw(32'h100),  1));
    tbl.push_back(mk(RUN,   0, 0, 0,            0, 32'h200, 1, 32'h200, iw(32'h200),  1));

    repeat (2) @(posedge clock);
    @(negedge clock);
    reset = 1'b0;
    #1;
    chk("reset.req",        32'(imem_req),    32'd1);
    chk("reset.addr",       imem_addr,        32'h0);
    chk("reset.ready",      32'(fetch_ready), 32'd0);
    chk("reset.ifid_pc",    ifid_pc,          32'h0);
    chk("reset.ifid_instr", ifid_instr,       NOP);
    chk("reset.ifid_valid", 32'(ifid_valid),  32'd0);

    foreach (tbl[i]) begin
      step($sformatf("row%0d", i), tbl[i].ctl, 1'b0, tbl[i].tgt, tbl[i].tgt,
           tbl[i].vld, tbl[i].rd, tbl[i].ereq, tbl[i].eaddr, tbl[i].erdy,
           tbl[i].epc, tbl[i].einstr, tbl[i].eval);
    end

    // Trap and branch together with a same-cycle response: trap wins, data dropped.
    step("trapprio", BR, 1'b1, 32'h200, 32'h080, 1, iw(32'h204),
         1, 32'h204, 1, 32'h200, iw(32'h200), 1);
    step("trapreq",  RUN, 0, 0, 0, 0, 0,            1, 32'h080, 0, 32'h200, iw(32'h200), 1);
    step("trapld",   RUN, 0, 0, 0, 1, iw(32'h080),  1, 32'h080, 1, 32'h080, iw(32'h080), 1);

    // Redirect inside S_KILL retargets; PC wraps past the top of memory.
    step("kill1",  RUN, 1'b1, 0, 32'h300, 0, 0,     1, 32'h084, 0, 32'h080, iw(32'h080), 1);
    step("kill2",  BR,  0, 32'hFFFF_FFFC, 0, 0, 0,  1, 32'h084, 0, 32'h080, iw(32'h080), 1);
    step("kill3",  RUN, 0, 0, 0, 1, 32'hDEADBEEF,   1, 32'h084, 0, 32'h080, iw(32'h080), 1);
    step("wrapreq", RUN, 0, 0, 0, 0, 0,             1, 32'hFFFF_FFFC, 0, 32'h080, iw(32'h080), 1);
    step("wrapld", RUN, 0, 0, 0, 1, iw(32'hFFFF_FFFC),
         1, 32'hFFFF_FFFC, 1, 32'hFFFF_FFFC, iw(32'hFFFF_FFFC), 1);
    step("wrap0",  RUN, 0, 0, 0, 0, 0,              1, 32'h000, 0, 32'hFFFF_FFFC, iw(32'hFFFF_FFFC), 1);

    // Reset asserted while a killed request is outstanding.
    step("prerst", RUN, 0, 0, 0, 1, iw(0),          1, 32'h000, 1, 32'h000, iw(0), 1);
    step("prekill", BR, 0, 32'h040, 0, 0, 0,        1, 32'h004, 0, 32'h000, iw(0), 1);
    @(negedge clock);
    {write_pc, write_ifid, bubble_ifid, instr_en, pc_src} = RUN;
    imem_valid = 1'b0;
    reset = 1'b1;
    #1;
    chk("midrst.req",        32'(imem_req),    32'd1);
    chk("midrst.addr",       imem_addr,        32'h0);
    chk("midrst.ready",      32'(fetch_ready), 32'd0);
    chk("midrst.ifid_pc",    ifid_pc,          32'h0);
    chk("midrst.ifid_instr", ifid_instr,       NOP);
    chk("midrst.ifid_valid", 32'(ifid_valid),  32'd0);
    @(posedge clock);
    @(negedge clock);
    reset = 1'b0;

`ifdef FETCH_MISALIGN_TRAP_EN
    // Misaligned target: no request, then {target, NOP, 1} with the flag set.
    step("mis_br",  BR,  0, 32'h102, 0, 1, iw(0),   1, 32'h000, 1, 32'h000, NOP, 0);
    step("mis_ld",  RUN, 0, 0, 0, 0, 0,             0, 32'h102, 1, 32'h102, NOP, 1);
    chk("mis_ld.flag", 32'(fetch_misaligned), 32'd1);
    step("mis_req", RUN, 0, 0, 0, 0, 0,             1, 32'h106, 0, 32'h102, NOP, 1);
    step("mis_clr", RUN, 0, 0, 0, 1, iw(32'h106),   1, 32'h106, 1, 32'h106, iw(32'h106), 1);
    chk("mis_clr.flag", 32'(fetch_misaligned), 32'd0);
`else
    // Without misaligned trapping the low target bits are forced to zero.
    step("align_br",  BR,  0, 32'h203, 0, 1, iw(0), 1, 32'h000, 1, 32'h000, NOP, 0);
    step("align_req", RUN, 0, 0, 0, 0, 0,           1, 32'h200, 0, 32'h000, NOP, 0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
